// File: rtl/demux1to3_buf.sv
// One-to-three demultiplexer with a single output register per channel.
// Illegal destinations are accepted, discarded and tallied in err/err_cnt.
module demux1to3_buf #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             o1_valid,
  output logic [WIDTH-1:0] o1_data,
  input  logic             o1_ready,
  output logic             o2_valid,
  output logic [WIDTH-1:0] o2_data,
  input  logic             o2_ready,
  output logic             o3_valid,
  output logic [WIDTH-1:0] o3_data,
  input  logic             o3_ready,
  input  logic             clr_err,
  output logic             err,
  output logic [7:0]       err_cnt
);

  logic [2:0]       valid_q, valid_d;
  logic [WIDTH-1:0] data_q [3];
  logic [WIDTH-1:0] data_d [3];
  logic             err_q, err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic [2:0] out_ready;
  logic [2:0] take;
  logic [2:0] load;
  logic       illegal_acc;

  // A full channel can still accept when it drains in the same cycle.
  always_comb begin
    out_ready = {o3_ready, o2_ready, o1_ready};
    take      = valid_q & out_ready;
    case (in_sel)
      2'b00:   in_ready = !valid_q[0] || take[0];
      2'b01:   in_ready = !valid_q[1] || take[1];
      2'b10:   in_ready = !valid_q[2] || take[2];
      default: in_ready = 1'b1;
    endcase
  end

  always_comb begin
    load        = '0;
    illegal_acc = in_valid && (in_sel == 2'b11);
    valid_d     = valid_q;
    data_d      = data_q;
    for (int i = 0; i < 3; i++) begin
      load[i] = in_valid && in_ready && (in_sel == 2'(i));
      if (load[i]) begin
        valid_d[i] = 1'b1;
        data_d[i]  = in_data;
      end else if (take[i]) begin
        valid_d[i] = 1'b0;
      end
    end

    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    // A clear coinciding with an illegal accept restarts the tally at one.
    if (clr_err) begin
      err_d     = illegal_acc;
      err_cnt_d = illegal_acc ? 8'd1 : 8'd0;
    end else if (illegal_acc) begin
      err_d     = 1'b1;
      err_cnt_d = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      data_q[0] <= '0;
      data_q[1] <= '0;
      data_q[2] <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      data_q[0] <= data_d[0];
      data_q[1] <= data_d[1];
      data_q[2] <= data_d[2];
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o1_valid = valid_q[0];
  assign o2_valid = valid_q[1];
  assign o3_valid = valid_q[2];
  assign o1_data  = data_q[0];
  assign o2_data  = data_q[1];
  assign o3_data  = data_q[2];
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_demux1to3_buf.sv
// Directed, table-driven bench for demux1to3_buf with hand-computed
// expectations, plus an error-counter saturation sequence.
module tb_demux1to3_buf;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] in_data;
  logic             o1_valid, o2_valid, o3_valid;
  logic [WIDTH-1:0] o1_data, o2_data, o3_data;
  logic             o1_ready, o2_ready, o3_ready;
  logic             clr_err;
  logic             err;
  logic [7:0]       err_cnt;

  demux1to3_buf #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .o1_valid (o1_valid),
    .o1_data  (o1_data),
    .o1_ready (o1_ready),
    .o2_valid (o2_valid),
    .o2_data  (o2_data),
    .o2_ready (o2_ready),
    .o3_valid (o3_valid),
    .o3_data  (o3_data),
    .o3_ready (o3_ready),
    .clr_err  (clr_err),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per clock: inputs held for that cycle, in_ready expected
  // before the edge, register contents expected after it.
  typedef struct {
    logic        rst;
    logic        vld;
    logic [1:0]  sel;
    logic [15:0] data;
    logic [2:0]  rdy;
    logic        clr;
    logic        chk_rdy;
    logic        exp_rdy;
    logic [2:0]  exp_v;
    logic [15:0] e1, e2, e3;
    logic        exp_err;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vq[$];
  int   n_vec;
  int   n_miss;

  task automatic addVec(input logic r, input logic v, input logic [1:0] s,
                        input logic [15:0] d, input logic [2:0] rd, input logic c,
                        input logic ck, input logic er, input logic [2:0] ev,
                        input logic [15:0] e1, input logic [15:0] e2,
                        input logic [15:0] e3, input logic ee, input logic [7:0] ec);
    vec_t t;
    t.rst = r; t.vld = v; t.sel = s; t.data = d; t.rdy = rd; t.clr = c;
    t.chk_rdy = ck; t.exp_rdy = er; t.exp_v = ev;
    t.e1 = e1; t.e2 = e2; t.e3 = e3; t.exp_err = ee; t.exp_cnt = ec;
    vq.push_back(t);
  endtask

  task automatic applyStimulus(input vec_t t);
    rst      = t.rst;
    in_valid = t.vld;
    in_sel   = t.sel;
    in_data  = t.data;
    {o3_ready, o2_ready, o1_ready} = t.rdy;
    clr_err  = t.clr;
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [15:0] act, input logic [15:0] req);
    if (act !== req) begin
      n_miss++;
      $display("[TB] FAIL %s vec %0d: got %h, expected %h", name, idx, act, req);
    end
  endtask

  task automatic checkState(input int idx, input vec_t t);
    checkOutput("valids", idx, {13'd0, o3_valid, o2_valid, o1_valid}, {13'd0, t.exp_v});
    checkOutput("o1_data", idx, o1_data, t.e1);
    checkOutput("o2_data", idx, o2_data, t.e2);
    checkOutput("o3_data", idx, o3_data, t.e3);
    checkOutput("err", idx, {15'd0, err}, {15'd0, t.exp_err});
    checkOutput("err_cnt", idx, {8'd0, err_cnt}, {8'd0, t.exp_cnt});
  endtask

  initial begin
    vec_t idle;
    n_vec  = 0;
    n_miss = 0;
    idle = '{rst:0, vld:0, sel:0, data:0, rdy:0, clr:0, chk_rdy:0, exp_rdy:0,
             exp_v:0, e1:0, e2:0, e3:0, exp_err:0, exp_cnt:0};
    applyStimulus(idle);

    //     rst vld sel    data      rdy     clr ck  rdy  valid   o1        o2        o3      err cnt
    addVec(1, 0, 2'b00, 16'h0000, 3'b000, 0, 0, 0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 0, 8'd0);
    addVec(1, 0, 2'b00, 16'h0000, 3'b000, 0, 1, 1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 0, 8'd0);
    addVec(0, 1, 2'b01, 16'h1234, 3'b000, 0, 1, 1, 3'b010, 16'h0000, 16'h1234, 16'h0000, 0, 8'd0);
    addVec(0, 1, 2'b01, 16'h5555, 3'b000, 0, 1, 0, 3'b010, 16'h0000, 16'h1234, 16'h0000, 0, 8'd0);
    addVec(0, 1, 2'b10, 16'hABCD, 3'b000, 0, 1, 1, 3'b110, 16'h0000, 16'h1234, 16'hABCD, 0, 8'd0);
    addVec(0, 1, 2'b00, 16'h0001, 3'b001, 0, 1, 1, 3'b111, 16'h0001, 16'h1234, 16'hABCD, 0, 8'd0);
    addVec(0, 1, 2'b00, 16'h0002, 3'b001, 0, 1, 1, 3'b111, 16'h0002, 16'h1234, 16'hABCD, 0, 8'd0);
    addVec(0, 1, 2'b00, 16'h0003, 3'b001, 0, 1, 1, 3'b111, 16'h0003, 16'h1234, 16'hABCD, 0, 8'd0);
    addVec(0, 0, 2'b00, 16'h0000, 3'b001, 0, 1, 1, 3'b110, 16'h0003, 16'h1234, 16'hABCD, 0, 8'd0);
    addVec(0, 0, 2'b00, 16'h0000, 3'b110, 0, 1, 1, 3'b000, 16'h0003, 16'h1234, 16'hABCD, 0, 8'd0);
    addVec(0, 1, 2'b11, 16'hFFFF, 3'b000, 0, 1, 1, 3'b000, 16'h0003, 16'h1234, 16'hABCD, 1, 8'd1);
    addVec(0, 1, 2'b11, 16'hFFFF, 3'b000, 0, 1, 1, 3'b000, 16'h0003, 16'h1234, 16'hABCD, 1, 8'd2);
    addVec(0, 1, 2'b11, 16'hFFFF, 3'b000, 0, 1, 1, 3'b000, 16'h0003, 16'h1234, 16'hABCD, 1, 8'd3);
    addVec(0, 1, 2'b11, 16'hFFFF, 3'b000, 1, 1, 1, 3'b000, 16'h0003, 16'h1234, 16'hABCD, 1, 8'd1);
    addVec(0, 0, 2'b00, 16'h0000, 3'b000, 1, 1, 1, 3'b000, 16'h0003, 16'h1234, 16'hABCD, 0, 8'd0);
    addVec(0, 0, 2'b11, 16'hDEAD, 3'b000, 0, 1, 1, 3'b000, 16'h0003, 16'h1234, 16'hABCD, 0, 8'd0);
    addVec(0, 1, 2'b01, 16'h0BEE, 3'b000, 0, 1, 1, 3'b010, 16'h0003, 16'h0BEE, 16'hABCD, 0, 8'd0);
    addVec(0, 1, 2'b01, 16'h0C0D, 3'b010, 0, 1, 1, 3'b010, 16'h0003, 16'h0C0D, 16'hABCD, 0, 8'd0);
    addVec(0, 1, 2'b01, 16'h7777, 3'b000, 0, 1, 0, 3'b010, 16'h0003, 16'h0C0D, 16'hABCD, 0, 8'd0);
    addVec(0, 1, 2'b00, 16'h1111, 3'b000, 0, 1, 1, 3'b011, 16'h1111, 16'h0C0D, 16'hABCD, 0, 8'd0);
    addVec(0, 1, 2'b10, 16'h3333, 3'b000, 0, 1, 1, 3'b111, 16'h1111, 16'h0C0D, 16'h3333, 0, 8'd0);
    addVec(0, 1, 2'b11, 16'h0000, 3'b000, 0, 1, 1, 3'b111, 16'h1111, 16'h0C0D, 16'h3333, 1, 8'd1);
    addVec(1, 1, 2'b00, 16'h9999, 3'b000, 0, 1, 0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 0, 8'd0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      applyStimulus(vq[i]);
      n_vec++;
      #1;
      if (vq[i].chk_rdy)
        checkOutput("in_ready", i, {15'd0, in_ready}, {15'd0, vq[i].exp_rdy});
      @(posedge clk);
      #1;
      checkState(i, vq[i]);
    end

    // Saturation: stream 300 illegal words and watch the counter stop at FF.
    @(negedge clk);
    idle.vld = 1'b1;
    idle.sel = 2'b11;
    applyStimulus(idle);
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      if (k == 254 || k == 255 || k == 300) begin
        n_vec++;
        checkOutput("sat_cnt", k, {8'd0, err_cnt}, (k == 254) ? 16'h00FE : 16'h00FF);
        checkOutput("sat_err", k, {15'd0, err}, 16'h0001);
        checkOutput("sat_valids", k, {13'd0, o3_valid, o2_valid, o1_valid}, 16'h0000);
      end
    end

    // Clearing with no illegal accept returns the counter to zero.
    @(negedge clk);
    idle.vld = 1'b0;
    idle.clr = 1'b1;
    applyStimulus(idle);
    n_vec++;
    @(posedge clk);
    #1;
    checkOutput("clr_cnt", 0, {8'd0, err_cnt}, 16'h0000);
    checkOutput("clr_err", 0, {15'd0, err}, 16'h0000);

    @(negedge clk);
    idle.clr = 1'b0;
    applyStimulus(idle);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/demux1to3_buf.md
DEMUX1TO3_BUF -- requirements
Module: demux1to3_buf

Interface
REQ-001 Parameter: WIDTH, default 16, data path width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  upstream word present.
REQ-005 in_ready  output  1  upstream word accepted this cycle when in_valid also high.
REQ-006 in_sel  input  2  destination: 2'b00 -> o1, 2'b01 -> o2, 2'b10 -> o3, 2'b11 illegal.
REQ-007 in_data  input  WIDTH  upstream word.
REQ-008 o1_valid, o2_valid, o3_valid  output  1 each  channel holds a word.
REQ-009 o1_data, o2_data, o3_data  output  WIDTH each  channel word.
REQ-010 o1_ready, o2_ready, o3_ready  input  1 each  downstream consumes the channel word.
REQ-011 clr_err  input  1  clears err and err_cnt.
REQ-012 err  output  1  sticky flag: illegal in_sel accepted.
REQ-013 err_cnt  output  8  saturating count of illegal words accepted.

Function
REQ-014 Each channel SHALL have one output register (valid bit + WIDTH data); ox_valid and ox_data SHALL be driven directly from that register.
REQ-015 Transfer on input SHALL occur when in_valid && in_ready; transfer on channel x SHALL occur when ox_valid && ox_ready.
REQ-016 in_ready SHALL be combinational: 1 when in_sel == 2'b11; otherwise 1 when selected channel is empty or transfers this cycle.
REQ-017 in_ready SHALL NOT depend on in_valid or on non-selected channels.
REQ-018 Legal accepted word SHALL appear on the selected channel with ox_valid = 1 on the cycle after acceptance (latency 1).
REQ-019 Channel transfer without a simultaneous load SHALL clear ox_valid next cycle; ox_data SHALL hold its last value.
REQ-020 Simultaneous channel transfer and load of the same channel SHALL keep ox_valid = 1 and replace ox_data with the new word (back-to-back, one word per cycle throughput).
REQ-021 While ox_valid && !ox_ready, ox_data and ox_valid SHALL remain stable.
REQ-022 Channels SHALL operate independently; a stalled channel SHALL NOT block words destined for another channel.
REQ-023 Non-selected channels SHALL never be modified by an input transfer.
REQ-024 Illegal word (in_sel == 2'b11) SHALL be accepted and discarded: no channel change, err set to 1 next cycle, err_cnt incremented by 1.
REQ-025 err_cnt SHALL saturate at 8'hFF; no wrap-around.
REQ-026 clr_err high SHALL clear err and err_cnt next cycle; clr_err and an illegal accept in the same cycle SHALL leave err = 1, err_cnt = 1.
REQ-027 in_data and in_sel are don't-care when in_valid is low; no state change SHALL occur then except channel drains and clr_err.

Reset
REQ-028 rst high SHALL, at the next rising edge: clear o1/o2/o3_valid, zero o1/o2/o3_data, clear err, zero err_cnt.
REQ-029 rst SHALL take priority over every other input; any word held or being accepted during rst SHALL be discarded.
REQ-030 During rst high, in_ready SHALL still follow REQ-016 using post-reset-pending state; accepted words in that cycle are lost.

Verification
REQ-031 After reset, in_valid=1, sel=01, data=16'h1234, o2_ready=0 -> o2_valid=1, o2_data=16'h1234 next cycle; in_ready=0 for further sel=01 words; o1_valid=o3_valid=0.
REQ-032 o2 stalled holding 16'h1234, then in_sel=10 data=16'hABCD -> in_ready=1, o3_valid=1 with 16'hABCD next cycle; o2 unchanged.
REQ-033 o1_ready=1 held, stream sel=00 words 1,2,3 on consecutive cycles -> in_ready=1 every cycle, o1_data = 1,2,3 on the following consecutive cycles, o1_valid=1 throughout, 0 one cycle after the last.
REQ-034 Three words with sel=11 -> in_ready=1, no channel valid, err=1, err_cnt=3; then clr_err with one sel=11 in the same cycle -> err=1, err_cnt=1.
REQ-035 Saturation: 300 illegal words -> err_cnt=8'hFF.
REQ-036 All three channels loaded and stalled, rst=1 for one cycle -> all valids 0, data 0, err 0, err_cnt 0.
